// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    COL0,
    COL1,
    COL2,
    COL3
  } col_state_e;

  // Held/resolved key: bit 4 set means no key, else key index 4*col+row.
  localparam logic [4:0] KEY_NONE = 5'h10;

  localparam logic [15:0][3:0] KEY_LUT = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } evt_t;

  function automatic logic [3:0] key_code(
    input logic [3:0] idx
  );
    return KEY_LUT[idx];
  endfunction

  function automatic logic [4:0] lowest_key(
    input logic [15:0] raw
  );
    logic [4:0] k;
    k = KEY_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (raw[i]) k = 5'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: small synchronous event queue.
// A push into a full queue succeeds only when a pop happens in the same cycle.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  evt_t din,
  output evt_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  evt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: frame-based 4x4 keypad scanner with debounce and event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_code,
  output logic       evt_press,
  output logic       key_down,
  output logic       overflow
);

  localparam int         DW  = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [3:0]  row_s1_q;
  logic [3:0]  row_s2_q;
  col_state_e  state_q;
  logic [DW-1:0] div_q;
  logic [3:0]  col_q;
  logic [15:0] raw_q;
  logic [15:0] prev_raw_q;
  logic [3:0]  stable_q;
  logic [4:0]  held_q;
  logic        key_down_q;
  logic        overflow_q;
  logic        pend_q;
  logic        pend_d;
  logic [3:0]  pend_code_q;
  logic [3:0]  pend_code_d;

  logic        dwell_end;
  logic        frame_end;
  logic [3:0]  nib_lsb;
  logic [15:0] raw_full;
  logic [3:0]  stable_d;
  logic        commit;
  logic [4:0]  new_key;
  logic        change;
  logic        push_w;
  evt_t        push_evt;
  logic        pop_w;
  evt_t        head;
  logic        fifo_full;
  logic        fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign dwell_end = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end = dwell_end & (state_q == COL3);
  assign nib_lsb   = {state_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COL0;
      div_q   <= '0;
      col_q   <= 4'b1110;
      raw_q   <= '0;
    end else if (dwell_end) begin
      div_q              <= '0;
      raw_q[nib_lsb +: 4] <= ~row_s2_q;
      unique case (state_q)
        COL0: begin
          state_q <= COL1;
          col_q   <= 4'b1101;
        end
        COL1: begin
          state_q <= COL2;
          col_q   <= 4'b1011;
        end
        COL2: begin
          state_q <= COL3;
          col_q   <= 4'b0111;
        end
        COL3: begin
          state_q <= COL0;
          col_q   <= 4'b1110;
        end
        default: begin
          state_q <= COL0;
          col_q   <= 4'b1110;
        end
      endcase
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // The COL3 nibble is still in flight at frame end, so merge it here.
  assign raw_full = {~row_s2_q, raw_q[11:0]};
  assign stable_d = (raw_full != prev_raw_q) ? 4'd1
                  : (stable_q == DEB)      ? stable_q
                  :                          stable_q + 4'd1;
  assign commit   = frame_end & (stable_d == DEB);
  assign new_key  = lowest_key(raw_full);
  assign change   = commit & (new_key != held_q);

  always_comb begin
    push_w      = 1'b0;
    push_evt    = '0;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    if (pend_q) begin
      push_w   = 1'b1;
      push_evt = '{code: pend_code_q, press: 1'b1};
    end
    if (change) begin
`ifdef KEYPAD_RELEASE_EVT_EN
      push_w = 1'b1;
      if (held_q != KEY_NONE) begin
        push_evt = '{code: key_code(held_q[3:0]), press: 1'b0};
        if (new_key != KEY_NONE) begin
          pend_d      = 1'b1;
          pend_code_d = key_code(new_key[3:0]);
        end
      end else begin
        push_evt = '{code: key_code(new_key[3:0]), press: 1'b1};
      end
`else
      if (new_key != KEY_NONE) begin
        push_w   = 1'b1;
        push_evt = '{code: key_code(new_key[3:0]), press: 1'b1};
      end
`endif
    end
  end

  assign pop_w = evt_ready & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw_q  <= '0;
      stable_q    <= '0;
      held_q      <= KEY_NONE;
      key_down_q  <= 1'b0;
      overflow_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
    end else begin
      overflow_q  <= push_w & fifo_full & ~pop_w;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      if (frame_end) begin
        prev_raw_q <= raw_full;
        stable_q   <= stable_d;
      end
      if (commit) begin
        held_q     <= new_key;
        key_down_q <= (new_key != KEY_NONE);
      end
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_w),
    .pop   (pop_w),
    .din   (push_evt),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign col       = col_q;
  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;

`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt_press = head.press;
`else
  logic unused_press_w;
  assign unused_press_w = head.press;
  assign evt_press      = 1'b1;
`endif

endmodule
